tlul_lane_mask_unit: RTL and testbench
======================================

Name: tlul_lane_mask_unit

Overview:
- Byte-lane masking datapath for a TL-UL slave memory.
- Combines three functions:
  - size-to-byte-mask expansion;
  - memory-to-lane masked read extraction;
  - lane-to-memory masked write merge.
- Exposes combinational results plus a one-cycle registered copy with a valid flag.
- Sits between the Channel A decode and the RAM array / Channel D response register.

Parameters:
- W, 8, bytes per data beat; power of two, ≥1.
- Z, 4, width of the TL-UL size field.
- BYTE_BIT, 8, bits per byte lane.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies the current input set for capture.
- size  input  Z  TL-UL log2 byte count (a_size).
- mask  input  W  per-byte lane enable (a_mask).
- mem_in  input  BYTE_BIT*W  current memory word at the addressed location.
- lane_in  input  BYTE_BIT*W  write data from the bus (a_data).
- size_mask  output  BYTE_BIT*W  combinational bit-expanded size mask.
- rd_data  output  BYTE_BIT*W  combinational masked read data.
- wr_data  output  BYTE_BIT*W  combinational merged write word.
- wr_strb  output  W  combinational effective byte enables.
- out_valid  output  1  registered; high one cycle after an accepted in_valid.
- rd_data_q  output  BYTE_BIT*W  registered rd_data.
- wr_data_q  output  BYTE_BIT*W  registered wr_data.
- wr_strb_q  output  W  registered wr_strb.

Behaviour:
- Byte count: n = 2^size.
  - If size ≥ log2(W), n = W (clamp; no wrap, no X).
- size_mask: byte lane i (bits [i*BYTE_BIT +: BYTE_BIT]) is all ones if i < n, else all zeros.
- wr_strb[i] = mask[i] AND (i < n).
- rd_data: lane i = mem_in lane i if mask[i], else 0.
  - Size does not affect rd_data; mask only.
- wr_data: lane i = lane_in lane i if wr_strb[i], else mem_in lane i.
  - Bytes disabled by mask or size always keep memory contents.
- Combinational outputs are purely functions of current inputs: zero latency, no dependency on in_valid.
- Register stage on each rising CLK edge:
  - RESET=1: out_valid, rd_data_q, wr_data_q and wr_strb_q all become 0. This overrides in_valid.
  - RESET=0, in_valid=1: the _q registers load the current combinational values; out_valid becomes 1.
  - RESET=0, in_valid=0: out_valid becomes 0; the _q data registers hold their previous values.
- Latency: exactly 1 cycle from accepted in_valid to out_valid.
  - Back-to-back in_valid keeps out_valid high, with a new capture every cycle.
- No backpressure: the block always accepts; the consumer must sample out_valid the cycle it is high.
- Power-on value of the registers is undefined until the first RESET cycle.
- No state machine; the only state is the output register set.
- Boundary cases:
  - mask=0 → rd_data=0, wr_strb=0, wr_data=mem_in.
  - size=0 → only lane 0 eligible.
  - W=1 → size_mask all ones for any size.

Test Plan (W=8, BYTE_BIT=8, Z=4):
- Size mask sweep: size=0 → size_mask=0x00000000000000FF; size=1 → 0x000000000000FFFF; size=2 → 0x00000000FFFFFFFF; size=3 → 0xFFFFFFFFFFFFFFFF; size=9 → 0xFFFFFFFFFFFFFFFF (clamp).
- Masked read: mem_in=0x0706050403020100, mask=0x0F, in_valid=1 for one cycle → rd_data=0x0000000003020100 combinationally; next cycle rd_data_q equals it and out_valid=1; following cycle out_valid=0 and rd_data_q held.
- Size-limited write: mem_in=0x0706050403020100, lane_in=0xAAAAAAAAAAAAAAAA, mask=0xFF, size=1 → wr_strb=0x03, wr_data=0x070605040302AAAA.
- Mask-limited write: same data, mask=0xA5, size=3 → wr_strb=0xA5, wr_data=0xAA06AA0403AA01AA.
- Reset priority: in_valid=1 and RESET=1 in the same cycle → next cycle out_valid=0 and all _q outputs 0. Deassert RESET with in_valid=1 → out_valid=1 one cycle later.
- Back-to-back: three consecutive in_valid cycles with mask=0x01, 0x02, 0x04 on mem_in=0x0706050403020100 → out_valid high for 3 cycles; rd_data_q = 0x00, 0x0100, 0x020000 in order.

Source files
------------

// File: rtl/tlul_lane_mask_unit.sv
// Byte-lane masking datapath for a TL-UL slave memory: size mask, masked read
// extraction, masked write merge, plus a one-cycle registered copy.
module tlul_lane_mask_unit #(
  parameter int unsigned W        = 8,
  parameter int unsigned Z        = 4,
  parameter int unsigned BYTE_BIT = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  in_valid,
  input  logic [Z-1:0]          size,
  input  logic [W-1:0]          mask,
  input  logic [BYTE_BIT*W-1:0] mem_in,
  input  logic [BYTE_BIT*W-1:0] lane_in,
  output logic [BYTE_BIT*W-1:0] size_mask,
  output logic [BYTE_BIT*W-1:0] rd_data,
  output logic [BYTE_BIT*W-1:0] wr_data,
  output logic [W-1:0]          wr_strb,
  output logic                  out_valid,
  output logic [BYTE_BIT*W-1:0] rd_data_q,
  output logic [BYTE_BIT*W-1:0] wr_data_q,
  output logic [W-1:0]          wr_strb_q
);

  localparam int unsigned LOG2W = (W > 1) ? $clog2(W) : 0;

  logic [31:0]  size_ext;
  logic [W-1:0] lane_ok;

  assign size_ext = 32'(size);

  // Sizes at or beyond the beat width clamp to the full beat, so the shift
  // below is only evaluated for size < LOG2W and can never overflow.
  always_comb begin
    lane_ok = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (size_ext >= LOG2W) begin
        lane_ok[i] = 1'b1;
      end else begin
        lane_ok[i] = (i < (32'd1 << size_ext));
      end
    end
  end

  always_comb begin
    size_mask = '0;
    rd_data   = '0;
    wr_data   = '0;
    wr_strb   = '0;
    for (int unsigned i = 0; i < W; i++) begin
      wr_strb[i] = mask[i] & lane_ok[i];
      size_mask[i*BYTE_BIT +: BYTE_BIT] = {BYTE_BIT{lane_ok[i]}};
      rd_data[i*BYTE_BIT +: BYTE_BIT]   = mask[i] ? mem_in[i*BYTE_BIT +: BYTE_BIT]
                                                  : {BYTE_BIT{1'b0}};
      wr_data[i*BYTE_BIT +: BYTE_BIT]   = (mask[i] & lane_ok[i])
                                          ? lane_in[i*BYTE_BIT +: BYTE_BIT]
                                          : mem_in[i*BYTE_BIT +: BYTE_BIT];
    end
  end

  // Data registers hold when idle; only out_valid tracks in_valid every cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid <= 1'b0;
      rd_data_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        rd_data_q <= rd_data;
        wr_data_q <= wr_data;
        wr_strb_q <= wr_strb;
      end
    end
  end

endmodule

// File: tb/tb_tlul_lane_mask_unit.sv
// Directed and randomized self-checking bench for tlul_lane_mask_unit (W=8).
module tb_tlul_lane_mask_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic [3:0]  size;
  logic [7:0]  mask;
  logic [63:0] mem_in;
  logic [63:0] lane_in;
  logic [63:0] size_mask, rd_data, wr_data, rd_data_q, wr_data_q;
  logic [7:0]  wr_strb, wr_strb_q;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  tlul_lane_mask_unit #(.W(8), .Z(4), .BYTE_BIT(8)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .size(size), .mask(mask),
    .mem_in(mem_in), .lane_in(lane_in), .size_mask(size_mask), .rd_data(rd_data),
    .wr_data(wr_data), .wr_strb(wr_strb), .out_valid(out_valid),
    .rd_data_q(rd_data_q), .wr_data_q(wr_data_q), .wr_strb_q(wr_strb_q)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte count n, then per-byte decisions using plain arithmetic.
  task automatic model(input logic [3:0] sz, input logic [7:0] m,
                       input logic [63:0] mem, input logic [63:0] lane,
                       output logic [63:0] e_sm, output logic [63:0] e_rd,
                       output logic [63:0] e_wd, output logic [7:0] e_st);
    int n;
    logic [63:0] mb, lb;
    n = (sz >= 3) ? 8 : (1 << sz);
    e_sm = 0; e_rd = 0; e_wd = 0; e_st = 0;
    for (int b = 0; b < 8; b++) begin
      mb = (mem >> (8 * b)) & 64'hFF;
      lb = (lane >> (8 * b)) & 64'hFF;
      if (b < n) e_sm = e_sm + (64'hFF << (8 * b));
      if (m[b]) e_rd = e_rd + (mb << (8 * b));
      if (m[b] && b < n) begin
        e_st = e_st + 8'(1 << b);
        e_wd = e_wd + (lb << (8 * b));
      end else begin
        e_wd = e_wd + (mb << (8 * b));
      end
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  logic [63:0] e_sm, e_rd, e_wd, h_rd, h_wd;
  logic [7:0]  e_st, h_st;
  logic        h_v;
  logic [3:0]  sweep_sz [5];
  logic [63:0] sweep_exp [5];

  initial begin
    RESET = 1'b1; in_valid = 1'b0; size = 0; mask = 0; mem_in = 0; lane_in = 0;
    tick; tick;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_rd_q", rd_data_q, 64'd0);
    chk("reset_wr_q", wr_data_q, 64'd0);
    chk("reset_strb_q", 64'(wr_strb_q), 64'd0);

    @(negedge CLK) RESET = 1'b0;

    sweep_sz  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9};
    sweep_exp = '{64'h00000000000000FF, 64'h000000000000FFFF, 64'h00000000FFFFFFFF,
                  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    for (int k = 0; k < 5; k++) begin
      size = sweep_sz[k];
      #1 chk($sformatf("size_mask_sz%0d", sweep_sz[k]), size_mask, sweep_exp[k]);
    end

    // Masked read and hold
    @(negedge CLK);
    mem_in = 64'h0706050403020100; mask = 8'h0F; size = 3; in_valid = 1'b1;
    #1 chk("rd_comb", rd_data, 64'h0000000003020100);
    tick;
    chk("rd_q", rd_data_q, 64'h0000000003020100);
    chk("rd_out_valid", 64'(out_valid), 64'd1);
    @(negedge CLK) in_valid = 1'b0; mask = 8'hFF;
    tick;
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("rd_q_held", rd_data_q, 64'h0000000003020100);

    // Size- and mask-limited writes
    @(negedge CLK);
    lane_in = 64'hAAAAAAAAAAAAAAAA; mask = 8'hFF; size = 1;
    #1 chk("szlim_strb", 64'(wr_strb), 64'h03);
    chk("szlim_wd", wr_data, 64'h070605040302AAAA);
    mask = 8'hA5; size = 3;
    #1 chk("mklim_strb", 64'(wr_strb), 64'hA5);
    chk("mklim_wd", wr_data, 64'hAA06AA0403AA01AA);
    mask = 8'h00;
    #1 chk("mask0_rd", rd_data, 64'd0);
    chk("mask0_strb", 64'(wr_strb), 64'd0);
    chk("mask0_wd", wr_data, mem_in);

    // Reset overrides in_valid
    @(negedge CLK) mask = 8'hFF; in_valid = 1'b1; RESET = 1'b1;
    tick;
    chk("rstpri_out_valid", 64'(out_valid), 64'd0);
    chk("rstpri_rd_q", rd_data_q, 64'd0);
    chk("rstpri_wr_q", wr_data_q, 64'd0);
    chk("rstpri_strb_q", 64'(wr_strb_q), 64'd0);
    @(negedge CLK) RESET = 1'b0;
    tick;
    chk("post_rst_out_valid", 64'(out_valid), 64'd1);

    // Back-to-back captures
    @(negedge CLK) lane_in = 0; mask = 8'h01;
    tick;
    chk("b2b0_v", 64'(out_valid), 64'd1);
    chk("b2b0_rd_q", rd_data_q, 64'h00);
    @(negedge CLK) mask = 8'h02;
    tick;
    chk("b2b1_v", 64'(out_valid), 64'd1);
    chk("b2b1_rd_q", rd_data_q, 64'h0100);
    @(negedge CLK) mask = 8'h04;
    tick;
    chk("b2b2_v", 64'(out_valid), 64'd1);
    chk("b2b2_rd_q", rd_data_q, 64'h020000);
    @(negedge CLK) in_valid = 1'b0;
    tick;
    chk("b2b_end_v", 64'(out_valid), 64'd0);

    // Randomized traffic against the reference model
    h_rd = rd_data_q; h_wd = wr_data_q; h_st = wr_strb_q;
    h_rd = 64'h020000;
    model(4'd3, 8'h04, 64'h0706050403020100, 64'd0, e_sm, e_rd, e_wd, e_st);
    h_wd = e_wd; h_st = e_st;
    for (int it = 0; it < 150; it++) begin
      @(negedge CLK);
      size = 4'($urandom_range(0, 15));
      mask = 8'($urandom);
      mem_in = {$urandom, $urandom};
      lane_in = {$urandom, $urandom};
      in_valid = 1'($urandom);
      model(size, mask, mem_in, lane_in, e_sm, e_rd, e_wd, e_st);
      #1;
      chk("rnd_size_mask", size_mask, e_sm);
      chk("rnd_rd", rd_data, e_rd);
      chk("rnd_wd", wr_data, e_wd);
      chk("rnd_strb", 64'(wr_strb), 64'(e_st));
      h_v = in_valid;
      if (in_valid) begin
        h_rd = e_rd; h_wd = e_wd; h_st = e_st;
      end
      tick;
      chk("rnd_out_valid", 64'(out_valid), 64'(h_v));
      chk("rnd_rd_q", rd_data_q, h_rd);
      chk("rnd_wd_q", wr_data_q, h_wd);
      chk("rnd_strb_q", 64'(wr_strb_q), 64'(h_st));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
